lsu_align: RTL and testbench

- Load/store alignment unit directly upstream of the word-wide data memory (DataMem) in the RISC-V core.
- Accepts byte/halfword/word load and store requests from the execute stage.
- Issues word-only read/write commands on the DataMem interface; sub-word stores become a read-modify-write sequence.
- Returns sign/zero-extended load data, or flags misaligned/illegal accesses without touching memory.

---
 rtl/lsu_align.sv | 191 +++++++++++++++++++
 tb/tb_lsu_align.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// Load/store alignment unit in front of the word-wide DataMem: turns byte/half/word
// requests into word reads/writes, with read-modify-write for sub-word stores.
module lsu_align (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [31:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  input  logic        io_req_fcn,
  input  logic [2:0]  io_req_typ,
  output logic        io_resp_valid,
  output logic [31:0] io_resp_data,
  output logic        io_resp_misaligned,
  output logic        io_resp_illegal,
  output logic [31:0] io_mem_addr,
  output logic [31:0] io_mem_wr_data,
  output logic [1:0]  io_mem_func,
  output logic        io_mem_en,
  input  logic [31:0] io_mem_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_ERR    = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  typ_q, typ_d;
  logic [31:0] merged_q, merged_d;
  logic        err_mis_q, err_mis_d;
  logic        err_ill_q, err_ill_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_mis_q, resp_mis_d;
  logic        resp_ill_q, resp_ill_d;
  logic        req_illegal_s;
  logic        req_misaligned_s;

  // BU/HU only make sense for loads; everything outside B/H/W/BU/HU is illegal.
  function automatic logic typ_illegal(input logic fcn, input logic [2:0] typ);
    logic ill;
    case (typ)
      3'b000, 3'b001, 3'b010: ill = 1'b0;
      3'b100, 3'b101:         ill = fcn;
      default:                ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] off,
                                          input logic [2:0] typ);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (typ)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] wd,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00:   r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign req_illegal_s    = typ_illegal(io_req_fcn, io_req_typ);
  assign req_misaligned_s = ((io_req_typ[1:0] == 2'b01) && io_req_addr[0]) ||
                            ((io_req_typ[1:0] == 2'b10) && (io_req_addr[1:0] != 2'b00));

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      typ_q       <= 3'b000;
      merged_q    <= 32'h0;
      err_mis_q   <= 1'b0;
      err_ill_q   <= 1'b0;
      resp_data_q <= 32'h0;
      resp_mis_q  <= 1'b0;
      resp_ill_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      typ_q       <= typ_d;
      merged_q    <= merged_d;
      err_mis_q   <= err_mis_d;
      err_ill_q   <= err_ill_d;
      resp_data_q <= resp_data_d;
      resp_mis_q  <= resp_mis_d;
      resp_ill_q  <= resp_ill_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    typ_d       = typ_q;
    merged_d    = merged_q;
    err_mis_d   = err_mis_q;
    err_ill_d   = err_ill_q;
    resp_data_d = resp_data_q;
    resp_mis_d  = resp_mis_q;
    resp_ill_d  = resp_ill_q;
    case (state_q)
      S_IDLE: begin
        if (io_req_valid) begin
          addr_d    = io_req_addr;
          wdata_d   = io_req_wdata;
          typ_d     = io_req_typ;
          err_ill_d = req_illegal_s;
          err_mis_d = !req_illegal_s && req_misaligned_s;
          if (req_illegal_s || req_misaligned_s) begin
            state_d = S_ERR;
          end else if (!io_req_fcn) begin
            state_d = S_LOAD;
          end else if (io_req_typ == 3'b010) begin
            merged_d = io_req_wdata;
            state_d  = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        resp_data_d = extract(io_mem_rd_data, addr_q[1:0], typ_q);
        state_d     = S_RESP;
      end
      S_RMW_RD: begin
        merged_d = merge_lane(io_mem_rd_data, wdata_q, addr_q[1:0], typ_q[1:0]);
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        resp_data_d = 32'h0;
        state_d     = S_RESP;
      end
      S_ERR: begin
        resp_data_d = 32'h0;
        resp_mis_d  = err_mis_q;
        resp_ill_d  = err_ill_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        resp_data_d = 32'h0;
        resp_mis_d  = 1'b0;
        resp_ill_d  = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so reset drops mem_en at once.
  assign io_req_ready       = (state_q == S_IDLE);
  assign io_resp_valid      = (state_q == S_RESP);
  assign io_resp_data       = resp_data_q;
  assign io_resp_misaligned = resp_mis_q;
  assign io_resp_illegal    = resp_ill_q;
  assign io_mem_addr        = {2'b00, addr_q[31:2]};
  assign io_mem_wr_data     = merged_q;
  assign io_mem_en          = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_WRITE);
  assign io_mem_func        = (state_q == S_WRITE) ? 2'h1 : 2'h0;

endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: word memory model plus an arithmetic reference model.
module tb_lsu_align;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_req_valid, io_req_ready, io_req_fcn;
  logic [31:0] io_req_addr, io_req_wdata;
  logic [2:0]  io_req_typ;
  logic        io_resp_valid, io_resp_misaligned, io_resp_illegal;
  logic [31:0] io_resp_data, io_mem_addr, io_mem_wr_data, io_mem_rd_data;
  logic [1:0]  io_mem_func;
  logic        io_mem_en;

  logic [31:0] mem [0:15];
  logic [31:0] exp_mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'h0;
  logic [31:0] pl_val = 32'h0;
  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  int          total = 0, bad = 0;

  lsu_align dut (
    .clk(clk), .reset_n(reset_n),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata),
    .io_req_fcn(io_req_fcn), .io_req_typ(io_req_typ),
    .io_resp_valid(io_resp_valid), .io_resp_data(io_resp_data),
    .io_resp_misaligned(io_resp_misaligned), .io_resp_illegal(io_resp_illegal),
    .io_mem_addr(io_mem_addr), .io_mem_wr_data(io_mem_wr_data),
    .io_mem_func(io_mem_func), .io_mem_en(io_mem_en),
    .io_mem_rd_data(io_mem_rd_data)
  );

  always #5 clk = ~clk;

  assign io_mem_rd_data = mem[io_mem_addr[3:0]];

  // DataMem model with activity counters.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (io_mem_en && io_mem_func == 2'h1) begin
      mem[io_mem_addr[3:0]] <= io_mem_wr_data;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= io_mem_addr;
    end
    if (io_mem_en && io_mem_func == 2'h0) rd_cnt <= rd_cnt + 1;
  end

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 4'(idx); pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
    exp_mem[idx] = val;
  endtask

  function automatic logic [54:0] pk(input logic [31:0] d, input logic m, input logic i,
                                     input int lat, input int nr, input int nw, input int busy,
                                     input logic clr);
    return {d, m, i, lat[7:0], nr[3:0], nw[3:0], busy[3:0], clr};
  endfunction

  // Reference: result of one request on word w, from the access-size rules.
  task automatic model(input logic f, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] w,
                       output logic [54:0] ev, output logic [31:0] nw);
    int size, sh, lat, nrd, nwr;
    logic ill, mis;
    longint unsigned lmask, mask, v;
    logic [31:0] d;
    ill = !(t == 0 || t == 1 || t == 2 || t == 4 || t == 5) || (f && t >= 4);
    size = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
    mis = !ill && ((a % size) != 0);
    sh = int'(a[1:0]) * 8;
    lmask = (64'd1 << (size * 8)) - 64'd1;
    mask = lmask << sh;
    d = 32'h0; nw = w; nrd = 0; nwr = 0; lat = 2;
    if (!ill && !mis) begin
      if (!f) begin
        nrd = 1;
        v = (longint'(w) >> sh) & lmask;
        if (t < 4 && size < 4 && v[size * 8 - 1]) v = v | ~lmask;
        d = v[31:0];
      end else begin
        nwr = 1;
        v = (longint'(w) & ~mask) | ((longint'(wd) << sh) & mask);
        nw = v[31:0];
        if (size < 4) begin nrd = 1; lat = 3; end
      end
    end
    ev = pk(d, mis, ill, lat, nrd, nwr, 0, 1'b1);
  endtask

  task automatic do_req(input logic f, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] wd, output logic [54:0] ov);
    int r0, w0, lat, busy;
    logic [31:0] d;
    logic m, i, clr;
    @(negedge clk);
    io_req_valid = 1'b1; io_req_fcn = f; io_req_typ = t; io_req_addr = a; io_req_wdata = wd;
    for (int k = 0; k < 20 && !io_req_ready; k++) @(negedge clk);
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk); #1;
    io_req_valid = 1'b0;
    lat = -1; busy = 0; d = 32'h0; m = 1'b0; i = 1'b0;
    for (int n = 1; n <= 8 && lat < 0; n++) begin
      @(negedge clk);
      if (io_resp_valid) begin
        lat = n; d = io_resp_data; m = io_resp_misaligned; i = io_resp_illegal;
      end else if (io_req_ready) busy++;
    end
    @(negedge clk);
    clr = !io_resp_valid && io_resp_data == 32'h0 && !io_resp_misaligned && !io_resp_illegal;
    ov = pk(d, m, i, lat, rd_cnt - r0, wr_cnt - w0, busy, clr);
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({io_req_ready, io_resp_valid, io_resp_misaligned, io_resp_illegal, io_mem_en, io_mem_func, io_resp_data}
        !== {5'b10000, 2'h0, 32'h0}) begin
      bad++; $display("FAIL reset_hold got=%b/%b/%b/%b/%b/%h/%h want=1/0/0/0/0/0/0", io_req_ready,
                      io_resp_valid, io_resp_misaligned, io_resp_illegal, io_mem_en, io_mem_func, io_resp_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({io_req_ready, io_resp_valid, io_mem_en} !== 3'b100) begin
      bad++; $display("FAIL reset_release got ready/rv/en=%b%b%b want=100", io_req_ready, io_resp_valid, io_mem_en);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  tt [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
    logic [31:0] aa [4] = '{32'h1, 32'h1, 32'h2, 32'h0};
    logic [31:0] dd [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8070, 32'h8070F0A5};
    logic [54:0] ov, ev;
    preload(0, 32'h8070F0A5);
    for (int k = 0; k < 4; k++) begin
      do_req(1'b0, tt[k], aa[k], 32'h0, ov);
      ev = pk(dd[k], 1'b0, 1'b0, 2, 1, 0, 0, 1'b1);
      total++;
      if (ov !== ev) begin bad++; $display("FAIL load_%0d got=%h want=%h", k, ov, ev); end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  tt [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] aa [3] = '{32'h2, 32'h0, 32'h4};
    logic [31:0] ww [3] = '{32'h000000AB, 32'h0000BEEF, 32'hDEADBEEF};
    logic [31:0] nn [3] = '{32'h11AB3344, 32'h1122BEEF, 32'hDEADBEEF};
    int          ll [3] = '{3, 3, 2};
    int          rr [3] = '{1, 1, 0};
    logic [54:0] ov, ev;
    for (int k = 0; k < 3; k++) begin
      preload(int'(aa[k][5:2]), 32'h11223344);
      do_req(1'b1, tt[k], aa[k], ww[k], ov);
      ev = pk(32'h0, 1'b0, 1'b0, ll[k], rr[k], 1, 0, 1'b1);
      total++;
      if (ov !== ev) begin bad++; $display("FAIL store_%0d got=%h want=%h", k, ov, ev); end
      total++;
      if ({mem[aa[k][5:2]], last_wr_addr} !== {nn[k], 2'b00, aa[k][31:2]}) begin
        bad++; $display("FAIL store_mem_%0d got=%h@%h want=%h@%h", k, mem[aa[k][5:2]], last_wr_addr,
                        nn[k], {2'b00, aa[k][31:2]});
      end
    end
  endtask

  task automatic test_errors;
    logic        ff [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  tt [3] = '{3'b010, 3'b011, 3'b100};
    logic [31:0] aa [3] = '{32'h2, 32'h0, 32'h0};
    logic [1:0]  mi [3] = '{2'b10, 2'b01, 2'b01};
    logic [54:0] ov, ev;
    preload(0, 32'h55AA55AA);
    for (int k = 0; k < 3; k++) begin
      do_req(ff[k], tt[k], aa[k], 32'hFFFFFFFF, ov);
      ev = pk(32'h0, mi[k][1], mi[k][0], 2, 0, 0, 0, 1'b1);
      total++;
      if (ov !== ev || mem[0] !== 32'h55AA55AA) begin
        bad++; $display("FAIL error_%0d got=%h mem=%h want=%h mem=55aa55aa", k, ov, mem[0], ev);
      end
    end
  endtask

  task automatic test_back_to_back;
    int rn [$];
    logic [31:0] rd [$];
    int acc_n, busy;
    logic [31:0] nw;
    logic [54:0] ev;
    preload(0, 32'h8070F0A5);
    preload(2, 32'h11223344);
    model(1'b1, 3'b000, 32'h9, 32'h5A, exp_mem[2], ev, nw);
    @(negedge clk);
    io_req_valid = 1'b1; io_req_fcn = 1'b0; io_req_typ = 3'b010; io_req_addr = 32'h0; io_req_wdata = 32'h0;
    for (int k = 0; k < 20 && !io_req_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    io_req_fcn = 1'b1; io_req_typ = 3'b000; io_req_addr = 32'h9; io_req_wdata = 32'h5A;
    acc_n = -1; busy = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (io_resp_valid) begin rn.push_back(n); rd.push_back(io_resp_data); end
      if (io_req_ready && io_req_valid) begin
        acc_n = n;
        @(posedge clk); #1;
        io_req_valid = 1'b0;
      end else if (io_req_ready && n <= 6) busy++;
    end
    while (rn.size() < 2) begin rn.push_back(-1); rd.push_back(32'hX); end
    total++;
    if ({rn[0], rd[0], acc_n, rn[1], rd[1], busy} !== {2, 32'h8070F0A5, 3, 6, 32'h0, 0}) begin
      bad++; $display("FAIL back_to_back got r1@%0d=%h acc@%0d r2@%0d=%h busy=%0d want r1@2=8070f0a5 acc@3 r2@6=0 busy=0",
                      rn[0], rd[0], acc_n, rn[1], rd[1], busy);
    end
    total++;
    if (mem[2] !== nw) begin bad++; $display("FAIL back_to_back_mem got=%h want=%h", mem[2], nw); end
    exp_mem[2] = nw;
  endtask

  task automatic test_reset_mid_rmw;
    bit seen, rv;
    preload(3, 32'h11223344);
    @(negedge clk);
    io_req_valid = 1'b1; io_req_fcn = 1'b1; io_req_typ = 3'b000; io_req_addr = 32'hC; io_req_wdata = 32'hAB;
    for (int k = 0; k < 20 && !io_req_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    io_req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      seen = io_mem_en && io_mem_func == 2'h1;
    end
    reset_n = 1'b0; #1;
    total++;
    if (!seen || io_mem_en !== 1'b0) begin
      bad++; $display("FAIL reset_mid_rmw reached_write=%0b mem_en=%b want 1/0", seen, io_mem_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rv = rv | io_resp_valid;
    end
    total++;
    if ({io_req_ready, rv, mem[3]} !== {2'b10, 32'h11223344}) begin
      bad++; $display("FAIL reset_abort got ready=%b resp=%b mem=%h want ready=1 resp=0 mem=11223344",
                      io_req_ready, rv, mem[3]);
    end
  endtask

  task automatic test_random;
    logic f;
    logic [2:0] t;
    logic [31:0] a, wd, nw;
    logic [54:0] ov, ev;
    int idx;
    for (int k = 0; k < 16; k++) preload(k, $urandom);
    for (int k = 0; k < 60; k++) begin
      f = 1'($urandom_range(0, 1));
      t = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 63));
      wd = $urandom;
      idx = int'(a[5:2]);
      model(f, t, a, wd, exp_mem[idx], ev, nw);
      do_req(f, t, a, wd, ov);
      exp_mem[idx] = nw;
      total++;
      if (ov !== ev || mem[idx] !== nw) begin
        bad++; $display("FAIL random_%0d f=%b t=%0d a=%h got=%h mem=%h want=%h mem=%h",
                        k, f, t, a, ov, mem[idx], ev, nw);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    io_req_valid = 1'b0; io_req_fcn = 1'b0; io_req_typ = 3'b000;
    io_req_addr = 32'h0; io_req_wdata = 32'h0;
    for (int k = 0; k < 16; k++) exp_mem[k] = 32'h0;
    repeat (3) @(posedge clk);
    test_reset();
    for (int k = 0; k < 16; k++) preload(k, 32'h0);
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
